// File: rtl/div_mod_sequencer.sv
// Multi-cycle unsigned restoring divider for DIV/MOD in the EXE stage.
// Produces one quotient bit per clock and stalls the pipeline until the result is ready.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a DIV/MOD request; accepts one when not flushed
// BUSY  | one restoring-division step per cycle, DATA_W steps in total
// DONE  | result_valid pulse; always returns to IDLE on the next cycle
module div_mod_sequencer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_div,
    input  logic              op_mod,
    input  logic              flush,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              stall,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              op_sel_q, op_sel_d;
    logic              dbz_q, dbz_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              req;
    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] trial;
    logic              trial_neg;

    assign req = op_div | op_mod;

    // The remainder is kept one bit wider than the operands so the shift never drops a carry.
    assign shifted   = {rem_q, quo_q[DATA_W-1]};
    assign trial     = shifted - {2'b00, dvs_q};
    assign trial_neg = trial[DATA_W+1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        op_sel_d = op_sel_q;
        dbz_d    = dbz_q;
        result_d = result_q;
        stall    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req && !flush) begin
                    stall    = 1'b1;
                    op_sel_d = op_mod;
                    dvs_d    = divisor;
                    if (divisor != '0) begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_W'(DATA_W - 1);
                        rem_d   = '0;
                        quo_d   = dividend;
                    end else begin
                        state_d  = S_DONE;
                        quo_d    = '1;
                        rem_d    = {1'b0, dividend};
                        dbz_d    = 1'b1;
                        result_d = op_mod ? dividend : '1;
                    end
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    stall = 1'b1;
                    rem_d = trial_neg ? shifted[DATA_W:0] : trial[DATA_W:0];
                    quo_d = {quo_q[DATA_W-2:0], ~trial_neg};
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        dbz_d    = 1'b0;
                        result_d = op_sel_q ? rem_d[DATA_W-1:0] : quo_d;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            op_sel_q <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            op_sel_q <= op_sel_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    // A flush in the DONE cycle kills the pulse; the held result is simply never consumed.
    assign result_valid = (state_q == S_DONE) && !flush;
    assign result       = result_q;
    assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_div_mod_sequencer.sv
// Self-checking bench for div_mod_sequencer: directed test-plan cases with literal
// expectations, then randomized traffic checked every cycle against an arithmetic model.
module tb_div_mod_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, op_div, op_mod, flush;
    logic [W-1:0] dividend, divisor;
    logic         stall, result_valid, div_by_zero;
    logic [W-1:0] result;

    div_mod_sequencer #(.DATA_W(W), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_div      (op_div),
        .op_mod      (op_mod),
        .flush       (flush),
        .dividend    (dividend),
        .divisor     (divisor),
        .stall       (stall),
        .result      (result),
        .result_valid(result_valid),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: m_wait = -1 idle, >0 cycles still stalling, 0 = the result cycle.
    int           m_wait = -1;
    logic [W-1:0] m_res, m_last_res;
    logic         m_dbz, m_last_dbz;

    always @(posedge clk) begin
        if (rst) begin
            m_wait     = -1;
            m_last_res = '0;
            m_last_dbz = 1'b0;
        end else if (flush) begin
            m_wait = -1;
        end else if (m_wait < 0) begin
            if (op_div || op_mod) begin
                if (divisor == '0) begin
                    m_res  = op_mod ? dividend : '1;
                    m_dbz  = 1'b1;
                    m_wait = 0;
                end else begin
                    m_res  = op_mod ? (dividend % divisor) : (dividend / divisor);
                    m_dbz  = 1'b0;
                    m_wait = W;
                end
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            m_wait = -1;
        end
        if (!rst && !flush && m_wait == 0) begin
            m_last_res = m_res;
            m_last_dbz = m_dbz;
        end
    end

    always @(negedge clk) begin
        bit exp_stall, exp_valid;
        if (chk_en && !rst) begin
            exp_stall = flush ? 1'b0 : ((m_wait < 0) ? (op_div | op_mod) : (m_wait > 0));
            exp_valid = !flush && (m_wait == 0);
            chk("stall", stall, exp_stall);
            chk("result_valid", result_valid, exp_valid);
            chk("result", result, m_last_res);
            chk("div_by_zero", div_by_zero, m_last_dbz);
        end
    end

    task automatic drive(input bit d, input bit m, input bit f, input logic [W-1:0] a, input logic [W-1:0] b);
        op_div   = d;
        op_mod   = m;
        flush    = f;
        dividend = a;
        divisor  = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the request like a stalled pipeline would until the result pulse, then releases it.
    task automatic run_op(input bit m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input bit exp_dbz, input int exp_lat,
                          input string name);
        int t      = 0;
        int stalls = 0;
        bit seen   = 1'b0;
        drive(!m, m, 1'b0, a, b);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (result_valid) begin
                seen = 1'b1;
                chk({name, "_result"}, result, exp_res);
                chk({name, "_dbz"}, div_by_zero, exp_dbz);
                chk({name, "_latency"}, t, exp_lat);
                chk({name, "_stall_cycles"}, stalls, exp_lat);
            end else begin
                t++;
            end
            step();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no result_valid required=result_valid within 40 cycles", name);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int c0, v;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        step();
        rst    = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("reset_stall", stall, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_dbz", div_by_zero, 0);
        step();

        run_op(1'b0, 16'd100, 16'd7, 16'd14, 1'b0, 17, "div_100_7");
        @(negedge clk);
        chk("after_done_stall", stall, 0);
        chk("after_done_valid", result_valid, 0);
        step();

        run_op(1'b1, 16'd100, 16'd7, 16'd2, 1'b0, 17, "mod_100_7");
        run_op(1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 17, "div_ffff_1");
        run_op(1'b0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1, "div_by_0");
        run_op(1'b1, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1, "mod_by_0");

        // Flush in BUSY cycle 5 of a 50/3 DIV.
        drive(1'b1, 1'b0, 1'b0, 16'd50, 16'd3);
        repeat (5) step();
        drive(1'b1, 1'b0, 1'b1, 16'd50, 16'd3);
        @(negedge clk);
        chk("flush_stall", stall, 0);
        chk("flush_valid", result_valid, 0);
        step();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        v = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result_valid) v++;
            step();
        end
        chk("flush_no_pulse", v, 0);
        run_op(1'b1, 16'd9, 16'd4, 16'd1, 1'b0, 17, "mod_9_4");

        // Back-to-back DIVs.
        c0 = cyc;
        run_op(1'b0, 16'd20, 16'd4, 16'd5, 1'b0, 17, "b2b_20_4");
        run_op(1'b0, 16'd21, 16'd5, 16'd4, 1'b0, 17, "b2b_21_5");
        chk("b2b_total_cycles", cyc - c0, 2 * (W + 2));

        // Reset in the middle of BUSY.
        drive(1'b1, 1'b0, 1'b0, 16'd100, 16'd7);
        repeat (4) step();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_stall", stall, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_dbz", div_by_zero, 0);
        step();
        run_op(1'b0, 16'd10, 16'd3, 16'd3, 1'b0, 17, "div_10_3");

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            int          kind;
            logic [W-1:0] a, b;
            rst  = ($urandom_range(0, 299) == 0);
            kind = $urandom_range(0, 3);
            a    = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2, 3: b = W'($urandom_range(1, 20));
                default: b = W'($urandom);
            endcase
            drive(kind == 2, kind == 3, ($urandom_range(0, 15) == 0), a, b);
            step();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
